// File: rtl/sys_bus_pkg.sv
// Shared types and default sizing for the system bus arbiter.
//   state_t  : arbiter FSM states (IDLE, WAIT)
//   master_t : index of a bus master (M0 = core LSU, M1 = JTAG debug)
package sys_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_t;

  localparam int unsigned DEF_AW      = 32;
  localparam int unsigned DEF_DW      = 32;
  localparam int unsigned DEF_TIMEOUT = 255;

endpackage

// File: rtl/bus_rr_arb2.sv
// Two-way round-robin select with master-1 lock override.
//   clk, rst   : clock, synchronous active-high reset
//   req0/req1  : master requests
//   lock       : master-1 lock request
//   last_owner : owner of the most recent transaction
//   advance    : handshake; moves the pointer to the non-selected master
//   sel        : selected master (valid when sel_valid)
//   sel_valid  : a selectable request exists
module bus_rr_arb2
  import sys_bus_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    req0,
  input  logic    req1,
  input  logic    lock,
  input  master_t last_owner,
  input  logic    advance,
  output master_t sel,
  output logic    sel_valid
);

  master_t rr_q;

  always_comb begin
    sel       = rr_q;
    sel_valid = 1'b0;
    if (lock && last_owner == M1) begin
      // Locked: master 0 is invisible until the lock drops.
      sel       = M1;
      sel_valid = req1;
    end else if (req0 && req1) begin
      sel       = rr_q;
      sel_valid = 1'b1;
    end else if (req0) begin
      sel       = M0;
      sel_valid = 1'b1;
    end else if (req1) begin
      sel       = M1;
      sel_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= M0;
    end else if (advance) begin
      rr_q <= (sel == M0) ? M1 : M0;
    end
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Two-master to one-slave bus arbiter, one transaction outstanding.
//   clk, rst          : clock, synchronous active-high reset
//   m0_* / m1_*       : master request (req, we, addr, wdata, be) and
//                       response (gnt, rvalid, rdata, err) channels
//   s_*               : slave request/response channel
//   m1_lock           : master 1 keeps ownership while asserted
// A silent slave is answered with an error response after TIMEOUT cycles.
module sys_bus_arbiter
  import sys_bus_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_be,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  output logic            m0_err,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_be,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic            m1_err,
  input  logic            m1_lock,
  output logic            s_req,
  output logic            s_we,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_be,
  input  logic            s_gnt,
  input  logic            s_rvalid,
  input  logic [DW-1:0]   s_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  // WAIT is entered with the counter at 0, so the TIMEOUT-th cycle after
  // the handshake is the one where the counter reads TIMEOUT-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  master_t       owner_q;
  logic [CW-1:0] cnt_q;
  master_t       sel;
  logic          sel_valid;
  logic          hs;
  logic          resp_valid, resp_err;
  logic [DW-1:0] resp_data;

  bus_rr_arb2 u_rr (
    .clk        (clk),
    .rst        (rst),
    .req0       (m0_req),
    .req1       (m1_req),
    .lock       (m1_lock),
    .last_owner (owner_q),
    .advance    (hs),
    .sel        (sel),
    .sel_valid  (sel_valid)
  );

  always_comb begin
    state_d    = state_q;
    hs         = 1'b0;
    s_req      = 1'b0;
    s_we       = 1'b0;
    s_addr     = '0;
    s_wdata    = '0;
    s_be       = '0;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;
    m0_rvalid  = 1'b0;
    m0_err     = 1'b0;
    m0_rdata   = '0;
    m1_rvalid  = 1'b0;
    m1_err     = 1'b0;
    m1_rdata   = '0;

    case (state_q)
      IDLE: begin
        s_req   = sel_valid;
        s_we    = (sel == M1) ? m1_we    : m0_we;
        s_addr  = (sel == M1) ? m1_addr  : m0_addr;
        s_wdata = (sel == M1) ? m1_wdata : m0_wdata;
        s_be    = (sel == M1) ? m1_be    : m0_be;
        hs      = sel_valid && s_gnt;
        m0_gnt  = hs && (sel == M0);
        m1_gnt  = hs && (sel == M1);
        if (hs) state_d = WAIT;
      end
      WAIT: begin
        // A real response beats a coincident timeout.
        resp_valid = s_rvalid || (cnt_q == CNT_LAST);
        resp_err   = !s_rvalid;
        resp_data  = s_rvalid ? s_rdata : '0;
        if (resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (owner_q == M0) begin
      m0_rvalid = resp_valid;
      m0_err    = resp_valid && resp_err;
      m0_rdata  = resp_data;
    end else begin
      m1_rvalid = resp_valid;
      m1_err    = resp_valid && resp_err;
      m1_rdata  = resp_data;
    end

    // Outputs are forced quiet while reset is held; an outstanding
    // transaction is dropped without a response.
    if (rst) begin
      hs        = 1'b0;
      s_req     = 1'b0;
      s_we      = 1'b0;
      s_addr    = '0;
      s_wdata   = '0;
      s_be      = '0;
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      m0_rvalid = 1'b0;
      m0_err    = 1'b0;
      m0_rdata  = '0;
      m1_rvalid = 1'b0;
      m1_err    = 1'b0;
      m1_rdata  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= M0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        owner_q <= sel;
        cnt_q   <= '0;
      end else if (state_q == WAIT && !s_rvalid && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
module tb_sys_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 255;

  logic            clk = 1'b0;
  logic            rst;
  logic            m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [AW-1:0]   m0_addr;
  logic [DW-1:0]   m0_wdata, m0_rdata;
  logic [DW/8-1:0] m0_be;
  logic            m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [AW-1:0]   m1_addr;
  logic [DW-1:0]   m1_wdata, m1_rdata;
  logic [DW/8-1:0] m1_be;
  logic            m1_lock;
  logic            s_req, s_we, s_gnt, s_rvalid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata, s_rdata;
  logic [DW/8-1:0] s_be;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sys_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_err(m1_err), .m1_lock(m1_lock),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
  );

  // Inputs change 1 time unit after the rising edge; outputs are checked
  // on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    m1_lock = 0; s_gnt = 0; s_rvalid = 0; s_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    m0_req = 1; m1_req = 1; s_gnt = 1; s_rvalid = 1; s_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_cmp++;
    if ({m0_gnt, m1_gnt, s_req} !== 3'b000) begin
      n_bad++; $display("FAIL reset_gnt got %b want 000", {m0_gnt, m1_gnt, s_req});
    end
    n_cmp++;
    if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0000 || m0_rdata !== '0 || m1_rdata !== '0) begin
      n_bad++; $display("FAIL reset_resp got rv=%b%b err=%b%b rd0=%h rd1=%h want zeros",
                        m0_rvalid, m1_rvalid, m0_err, m1_err, m0_rdata, m1_rdata);
    end
    step();
    rst = 0;
    clear_inputs();
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1; m0_addr = 32'h2000_0000; m0_be = 4'hF; s_gnt = 1;
    @(negedge clk);
    n_cmp++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || s_req !== 1'b1) begin
      n_bad++; $display("FAIL single_gnt got m0=%b m1=%b sreq=%b want 1 0 1", m0_gnt, m1_gnt, s_req);
    end
    n_cmp++;
    if (s_addr !== 32'h2000_0000 || s_we !== 1'b0 || s_be !== 4'hF) begin
      n_bad++; $display("FAIL single_addr got %h we=%b be=%h want 20000000 0 f", s_addr, s_we, s_be);
    end
    step();
    m0_req = 0; s_gnt = 0;
    @(negedge clk);
    n_cmp++;
    if (s_req !== 1'b0 || m0_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL single_wait got sreq=%b rv=%b want 0 0", s_req, m0_rvalid);
    end
    step();
    step();
    s_rvalid = 1; s_rdata = 32'h1234_5678;
    @(negedge clk);
    n_cmp++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1234_5678 || m0_err !== 1'b0) begin
      n_bad++; $display("FAIL single_resp got rv=%b rd=%h err=%b want 1 12345678 0", m0_rvalid, m0_rdata, m0_err);
    end
    n_cmp++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== '0 || m1_err !== 1'b0 || m1_gnt !== 1'b0) begin
      n_bad++; $display("FAIL single_m1_quiet got rv=%b rd=%h err=%b gnt=%b want 0 0 0 0",
                        m1_rvalid, m1_rdata, m1_err, m1_gnt);
    end
    step();
    s_rvalid = 0; s_rdata = '0;
    @(negedge clk);
    n_cmp++;
    if (m0_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL single_pulse got rv=%b want 0", m0_rvalid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_seq [3];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;  // {m1_gnt, m0_gnt}
    do_reset();
    m0_req = 1; m0_addr = 32'h0000_0100; m0_wdata = 32'hAAAA_0000; m0_we = 1;
    m1_req = 1; m1_addr = 32'h0000_0200; m1_wdata = 32'hBBBB_0000; m1_we = 1;
    s_gnt = 1;
    for (int i = 0; i < 3; i++) begin
      s_rvalid = 0;
      @(negedge clk);
      n_cmp++;
      if ({m1_gnt, m0_gnt} !== exp_seq[i]) begin
        n_bad++; $display("FAIL rr_gnt%0d got %b want %b", i, {m1_gnt, m0_gnt}, exp_seq[i]);
      end
      n_cmp++;
      if (s_wdata !== (exp_seq[i][0] ? 32'hAAAA_0000 : 32'hBBBB_0000)) begin
        n_bad++; $display("FAIL rr_wdata%0d got %h", i, s_wdata);
      end
      step();
      s_rvalid = 1; s_rdata = 32'h0000_00C0 + i;
      @(negedge clk);
      n_cmp++;
      if (s_req !== 1'b0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0 ||
          {m1_rvalid, m0_rvalid} !== exp_seq[i]) begin
        n_bad++; $display("FAIL rr_wait%0d got sreq=%b gnt=%b%b rv=%b%b want 0 00 %b",
                          i, s_req, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, exp_seq[i]);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    logic early;
    early = 0;
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 32'h3000_0000; m1_wdata = 32'h5555_5555; s_gnt = 1;
    @(negedge clk);
    n_cmp++;
    if (m1_gnt !== 1'b1) begin
      n_bad++; $display("FAIL to_gnt got %b want 1", m1_gnt);
    end
    step();
    m1_req = 0; s_gnt = 0; s_rdata = 32'hDEAD_BEEF;
    for (int k = 1; k < TO; k++) begin
      @(negedge clk);
      if (m1_rvalid !== 1'b0) early = 1;
      step();
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_bad++; $display("FAIL to_early got %b want 0", early);
    end
    @(negedge clk);
    n_cmp++;
    if (m1_rvalid !== 1'b1 || m1_err !== 1'b1 || m1_rdata !== '0) begin
      n_bad++; $display("FAIL to_resp got rv=%b err=%b rd=%h want 1 1 0", m1_rvalid, m1_err, m1_rdata);
    end
    step();
    s_rvalid = 1; s_rdata = 32'h7777_7777;
    @(negedge clk);
    n_cmp++;
    if (m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0 || m1_rdata !== '0 || m0_rdata !== '0) begin
      n_bad++; $display("FAIL to_stray got rv=%b%b rd1=%h rd0=%h want 00 0 0",
                        m1_rvalid, m0_rvalid, m1_rdata, m0_rdata);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    m1_req = 1; s_gnt = 1;
    step();
    m1_req = 0; s_rvalid = 1;
    step();
    s_rvalid = 0;
    m1_lock = 1; m0_req = 1; m1_req = 1;
    for (int i = 0; i < 3; i++) begin
      s_rvalid = 0;
      @(negedge clk);
      n_cmp++;
      if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
        n_bad++; $display("FAIL lock_gnt%0d got m0=%b m1=%b want 0 1", i, m0_gnt, m1_gnt);
      end
      step();
      s_rvalid = 1;
      step();
    end
    s_rvalid = 0; m1_lock = 0;
    @(negedge clk);
    n_cmp++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      n_bad++; $display("FAIL unlock_gnt got m0=%b m1=%b want 1 0", m0_gnt, m1_gnt);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    m0_req = 1; s_gnt = 1;
    step();
    m0_req = 0; s_gnt = 0;
    rst = 1; s_rvalid = 1; s_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    n_cmp++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== '0) begin
      n_bad++; $display("FAIL rstwait_resp got rv=%b rd=%h want 0 0", m0_rvalid, m0_rdata);
    end
    step();
    rst = 0; s_rvalid = 0;
    m0_req = 1; m1_req = 1; s_gnt = 1;
    @(negedge clk);
    n_cmp++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || m0_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL rstwait_gnt got m0=%b m1=%b rv=%b want 1 0 0", m0_gnt, m1_gnt, m0_rvalid);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_resp_vs_timeout();
    do_reset();
    m0_req = 1; s_gnt = 1;
    step();
    m0_req = 0; s_gnt = 0;
    for (int k = 1; k < TO; k++) step();
    s_rvalid = 1; s_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    n_cmp++;
    if (m0_rvalid !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'hA5A5_A5A5) begin
      n_bad++; $display("FAIL race_resp got rv=%b err=%b rd=%h want 1 0 a5a5a5a5", m0_rvalid, m0_err, m0_rdata);
    end
    step();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_timeout();
    test_lock();
    test_reset_in_wait();
    test_resp_vs_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sys_bus_arbiter.md
SYS_BUS_ARBITER -- requirements
Module: sys_bus_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, address width.
REQ-002 The block SHALL have parameter DW, default 32, data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, the maximum number of cycles spent in WAIT before an error response.
REQ-004 The block SHALL have these clock and reset ports:
- clk  in  1  single system clock; all logic is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have these ports for master 0 (core load/store unit), x=0, and master 1 (JTAG debug module), x=1:
- mx_req  in  1  request valid.
- mx_we  in  1  write enable.
- mx_addr  in  AW  address.
- mx_wdata  in  DW  write data.
- mx_be  in  DW/8  byte enables.
- mx_gnt  out  1  request accepted.
- mx_rvalid  out  1  response valid, one-cycle pulse.
- mx_rdata  out  DW  read data.
- mx_err  out  1  error response, qualified by mx_rvalid.
REQ-006 The block SHALL have these slave-side ports:
- s_req  out  1  request valid.
- s_we  out  1  write enable.
- s_addr  out  AW  address.
- s_wdata  out  DW  write data.
- s_be  out  DW/8  byte enables.
- s_gnt  in  1  request accepted.
- s_rvalid  in  1  response valid.
- s_rdata  in  DW  read data.
REQ-007 The block SHALL have input m1_lock (1 bit): while asserted, master 1 keeps exclusive ownership between transactions.

Function
REQ-008 The state machine SHALL have two states: IDLE and WAIT. At most one transaction SHALL be outstanding at any time.
REQ-009 In IDLE, the arbiter SHALL select one requesting master combinationally:
- If only one master requests, select that master.
- If both request, select the master pointed to by the round-robin pointer rr.
REQ-010 In IDLE, the selected master's req, we, addr, wdata and be SHALL drive the s_* outputs in the same cycle.
REQ-011 In IDLE, mx_gnt SHALL equal s_gnt for the selected master and SHALL be 0 for the other master.
REQ-012 A handshake is s_req and s_gnt high in the same cycle. On a handshake the block SHALL:
- latch the owner;
- clear the timeout counter;
- move to WAIT on the next cycle;
- set rr to the non-owner.
REQ-013 In WAIT, s_req, m0_gnt and m1_gnt SHALL all be 0.
REQ-014 In WAIT, when s_rvalid is 1, the block SHALL drive, in the same cycle:
- owner rvalid = 1;
- owner rdata = s_rdata;
- owner err = 0.
It SHALL then return to IDLE. A new grant SHALL be possible no earlier than the following cycle.
REQ-015 In WAIT, the counter SHALL increment each cycle without s_rvalid. When the count equals TIMEOUT, the block SHALL drive a one-cycle response and return to IDLE:
- owner rvalid = 1;
- owner err = 1;
- owner rdata = 0.
REQ-016 If s_rvalid and the timeout occur in the same cycle, s_rvalid SHALL win and err SHALL be 0.
REQ-017 s_rvalid received in IDLE SHALL be ignored and SHALL NOT be forwarded to either master.
REQ-018 When m1_lock is 1 and the last owner was master 1, the arbiter SHALL select only master 1 in IDLE, and m0 requests SHALL wait.
REQ-019 Dropping m1_lock SHALL take effect on the next IDLE arbitration.
REQ-020 The non-owner's rvalid and err SHALL always be 0, and its rdata SHALL be 0.
REQ-021 The counter width SHALL be $clog2(TIMEOUT+1). The counter SHALL saturate and never wrap.

Reset
REQ-022 When rst is 1 at a rising edge of clk, the block SHALL set:
- state = IDLE;
- rr = master 0;
- owner = master 0;
- counter = 0.
REQ-023 Reset SHALL hold all mx_gnt, mx_rvalid, mx_err, mx_rdata and s_req outputs at 0 during reset.
REQ-024 Reset asserted in WAIT SHALL abandon the outstanding transaction without issuing any response.

Structure
REQ-025 Package sys_bus_pkg SHALL hold:
- the state enum {IDLE, WAIT};
- the master-index type;
- the default AW, DW and TIMEOUT constants.
REQ-026 The two-way round-robin select and pointer update, including the lock override, SHALL be one sub-module named bus_rr_arb2. The FSM, timeout counter and mux SHALL remain in sys_bus_arbiter.

Verification
REQ-027 Single master: m0 reads 0x2000_0000; slave grants in the same cycle and responds 3 cycles later with 0x1234_5678 -> m0_gnt is 1 in cycle 0; m0_rvalid=1 with m0_rdata=0x1234_5678 and m0_err=0 in cycle 3; m1 outputs stay 0.
REQ-028 Contention after reset: both request in the same cycle, slave zero-wait -> m0 granted first, then m1 granted; with both requesting continuously, grants alternate m0, m1, m0.
REQ-029 Timeout: m1 writes 0x3000_0000 and the slave never responds -> exactly TIMEOUT (255) cycles after the handshake, m1_rvalid=1, m1_err=1 and m1_rdata=0; a later stray s_rvalid is ignored.
REQ-030 Lock: m1_lock=1 after an m1 transaction while m0 and m1 both request -> m1 receives every grant; deasserting m1_lock -> m0 receives the next grant.
REQ-031 Reset in WAIT: assert rst for 1 cycle while m0 is outstanding -> no m0_rvalid; rr returns to m0; the next simultaneous request grants m0.
REQ-032 Simultaneous response and timeout: s_rvalid arrives exactly on the TIMEOUT cycle with s_rdata=0xA5A5_A5A5 -> owner sees err=0 and rdata=0xA5A5_A5A5.
